// File: rtl/twiddle9_seq.sv
// Twiddle-address sequencer for a 9-point DFT: walks k,n over 0..8 and emits (k*n) mod 9.
// Optional macro TWIDDLE9_SEQ_INV_EN adds port inv for conjugate (inverse) address order.
module twiddle9_seq #(
  parameter int BLOCKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ready,
`ifdef TWIDDLE9_SEQ_INV_EN
  input  logic       inv,
`endif
  output logic [3:0] tw_addr,
  output logic       tw_valid,
  output logic [3:0] tw_k,
  output logic [3:0] tw_n,
  output logic       sof,
  output logic       eof,
  output logic [7:0] blk_idx,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | waiting for start, all sideband outputs 0
  // RUN   | presenting beats, advancing on ready
  // DONE  | single-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] BLK_LAST = 8'(BLOCKS - 1);

  state_t     state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [3:0] n_q, n_d;
  logic [3:0] acc_q, acc_d;
  logic [7:0] blk_q, blk_d;
`ifdef TWIDDLE9_SEQ_INV_EN
  logic       inv_q, inv_d;
`endif

  logic       run;
  logic       last_n, last_k, last_blk, final_xfer;
  logic [4:0] acc_sum;
  logic [4:0] acc_wrap;
  logic [3:0] addr_sel;

  assign run        = (state_q == RUN);
  assign last_n     = (n_q == 4'd8);
  assign last_k     = (k_q == 4'd8);
  assign last_blk   = (blk_q == BLK_LAST);
  assign final_xfer = run && ready && last_n && last_k && last_blk;

  // Running sum of k replaces the k*n multiply; one conditional subtract keeps it mod 9.
  assign acc_sum  = {1'b0, acc_q} + {1'b0, k_q};
  assign acc_wrap = acc_sum - 5'd9;

`ifdef TWIDDLE9_SEQ_INV_EN
  assign addr_sel = (inv_q && (acc_q != 4'd0)) ? (4'd9 - acc_q) : acc_q;
`else
  assign addr_sel = acc_q;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    acc_d   = acc_q;
    blk_d   = blk_q;
`ifdef TWIDDLE9_SEQ_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = 4'd0;
          n_d     = 4'd0;
          acc_d   = 4'd0;
          blk_d   = 8'd0;
`ifdef TWIDDLE9_SEQ_INV_EN
          inv_d   = inv;
`endif
        end
      end
      RUN: begin
        if (ready) begin
          if (last_n) begin
            n_d   = 4'd0;
            acc_d = 4'd0;
            if (last_k) begin
              k_d   = 4'd0;
              blk_d = blk_q + 8'd1;
            end else begin
              k_d = k_q + 4'd1;
            end
          end else begin
            n_d   = n_q + 4'd1;
            acc_d = (acc_sum >= 5'd9) ? acc_wrap[3:0] : acc_sum[3:0];
          end
          if (final_xfer) begin
            state_d = DONE;
            blk_d   = 8'd0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
      n_q     <= 4'd0;
      acc_q   <= 4'd0;
      blk_q   <= 8'd0;
`ifdef TWIDDLE9_SEQ_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      blk_q   <= blk_d;
`ifdef TWIDDLE9_SEQ_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // Outputs decode straight from flops; gating by run forces zeros outside RUN.
  assign tw_valid = run;
  assign busy     = run;
  assign done     = (state_q == DONE);
  assign tw_addr  = run ? addr_sel : 4'd0;
  assign tw_k     = run ? k_q : 4'd0;
  assign tw_n     = run ? n_q : 4'd0;
  assign blk_idx  = run ? blk_q : 8'd0;
  assign sof      = run && (k_q == 4'd0) && (n_q == 4'd0);
  assign eof      = run && last_k && last_n;

endmodule

// File: tb/tb_twiddle9_seq.sv
// Scoreboard bench for twiddle9_seq: BLOCKS=1 and BLOCKS=3 instances, expected beats from a k*n mod 9 model.
module tb_twiddle9_seq;

  typedef struct packed {
    logic [3:0] k;
    logic [3:0] n;
    logic [3:0] addr;
    logic [7:0] blk;
    logic       sof;
    logic       eof;
  } beat_t;

  logic clk = 1'b0;
  logic rst, ready, start1, start3;
`ifdef TWIDDLE9_SEQ_INV_EN
  logic inv;
`endif
  logic [3:0] a1, k1, n1, a3, k3, n3;
  logic [7:0] b1, b3;
  logic v1, s1, e1, bz1, d1, v3, s3, e3, bz3, d3;

  int total = 0;
  int bad = 0;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int done_cnt, done_cyc, done_bad, hold_bad, tmo;

  always #5 clk = ~clk;

  twiddle9_seq #(.BLOCKS(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .ready(ready),
`ifdef TWIDDLE9_SEQ_INV_EN
    .inv(inv),
`endif
    .tw_addr(a1), .tw_valid(v1), .tw_k(k1), .tw_n(n1), .sof(s1), .eof(e1),
    .blk_idx(b1), .busy(bz1), .done(d1)
  );

  twiddle9_seq #(.BLOCKS(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .ready(ready),
`ifdef TWIDDLE9_SEQ_INV_EN
    .inv(inv),
`endif
    .tw_addr(a3), .tw_valid(v3), .tw_k(k3), .tw_n(n3), .sof(s3), .eof(e3),
    .blk_idx(b3), .busy(bz3), .done(d3)
  );

  // Expected beats pushed when the start is issued.
  task automatic build_exp(input int nblk, input bit inv_v);
    beat_t e;
    int a;
    exp_q.delete();
    for (int b = 0; b < nblk; b++)
      for (int k = 0; k < 9; k++)
        for (int n = 0; n < 9; n++) begin
          a = (k * n) % 9;
          if (inv_v && a != 0) a = 9 - a;
          e.k = 4'(k); e.n = 4'(n); e.addr = 4'(a); e.blk = 8'(b);
          e.sof = (k == 0 && n == 0);
          e.eof = (k == 8 && n == 8);
          exp_q.push_back(e);
        end
  endtask

  // Pulses start on one instance and records every accepted beat until a few cycles past done.
  task automatic run_seq(input bit big, input bit toggle, input bit restart);
    int cyc, post;
    bit held_v;
    beat_t cur, held;
    logic v, d;
    obs_q.delete();
    done_cnt = 0; done_cyc = -1; done_bad = 0; hold_bad = 0; tmo = 0;
    cyc = 0; post = -1; held_v = 0; held = '0;
    @(posedge clk); #1;
    if (big) start3 = 1'b1; else start1 = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    while (post != 0) begin
      if (toggle) ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      @(negedge clk);
      if (big) begin
        v = v3; d = d3;
        cur = '{k: k3, n: n3, addr: a3, blk: b3, sof: s3, eof: e3};
      end else begin
        v = v1; d = d1;
        cur = '{k: k1, n: n1, addr: a1, blk: b1, sof: s1, eof: e1};
      end
      if (held_v && cur !== held) hold_bad++;
      held_v = v && !ready;
      held = cur;
      if (v && ready) obs_q.push_back(cur);
      if (d) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (v || cur !== '0) done_bad++;
        if (post < 0) post = 4;
      end
      @(posedge clk); #1;
      start1 = 1'b0; start3 = 1'b0;
      if (restart && v && ready && cur.k == 4'd3 && cur.n == 4'd5) begin
        if (big) start3 = 1'b1; else start1 = 1'b1;
      end
      if (post > 0) post--;
      cyc++;
      if (cyc > 1500) begin
        tmo = 1;
        post = 0;
      end
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; start1 = 1'b0; start3 = 1'b0;
`ifdef TWIDDLE9_SEQ_INV_EN
    inv = 1'b0;
`endif
    #12;
    total++;
    if ({a1, v1, k1, n1, s1, e1, b1, bz1, d1} !== '0) begin
      bad++;
      $display("FAIL reset_u1 got %h want 0", {a1, v1, k1, n1, s1, e1, b1, bz1, d1});
    end
    total++;
    if ({a3, v3, k3, n3, s3, e3, b3, bz3, d3} !== '0) begin
      bad++;
      $display("FAIL reset_u3 got %h want 0", {a3, v3, k3, n3, s3, e3, b3, bz3, d3});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int k1_ref[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    int k2_ref[9] = '{0, 2, 4, 6, 8, 1, 3, 5, 7};
    int errs = 0;
    build_exp(1, 1'b0);
    run_seq(1'b0, 1'b0, 1'b0);
    total++;
    if (tmo !== 0) begin bad++; $display("FAIL single_timeout got %0d want 0", tmo); end
    total++;
    if (obs_q.size() !== 81) begin bad++; $display("FAIL single_count got %0d want 81", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL single_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int j = 0; j < 9; j++) begin
      total++;
      if (obs_q[9 + j].addr !== 4'(k1_ref[j])) begin
        bad++; $display("FAIL single_k1[%0d] got %0d want %0d", j, obs_q[9 + j].addr, k1_ref[j]);
      end
      total++;
      if (obs_q[18 + j].addr !== 4'(k2_ref[j])) begin
        bad++; $display("FAIL single_k2[%0d] got %0d want %0d", j, obs_q[18 + j].addr, k2_ref[j]);
      end
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL single_done_cnt got %0d want 1", done_cnt); end
    total++;
    if (done_cyc !== 81) begin bad++; $display("FAIL single_done_cyc got %0d want 81", done_cyc); end
    total++;
    if (done_bad !== 0) begin bad++; $display("FAIL single_done_outputs got %0d want 0", done_bad); end
  endtask

  task automatic test_ready_toggle();
    int errs = 0;
    build_exp(1, 1'b0);
    run_seq(1'b0, 1'b1, 1'b0);
    total++;
    if (obs_q.size() !== 81) begin bad++; $display("FAIL toggle_count got %0d want 81", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL toggle_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (hold_bad !== 0) begin bad++; $display("FAIL toggle_hold got %0d want 0", hold_bad); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL toggle_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart();
    int errs = 0;
    build_exp(1, 1'b0);
    run_seq(1'b0, 1'b0, 1'b1);
    total++;
    if (obs_q.size() !== 81) begin bad++; $display("FAIL restart_count got %0d want 81", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL restart_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL restart_done_cnt got %0d want 1", done_cnt); end
  endtask

`ifdef TWIDDLE9_SEQ_INV_EN
  task automatic test_inv();
    int k1_ref[9] = '{0, 8, 7, 6, 5, 4, 3, 2, 1};
    int errs = 0;
    inv = 1'b1;
    build_exp(1, 1'b1);
    run_seq(1'b0, 1'b0, 1'b0);
    inv = 1'b0;
    total++;
    if (obs_q.size() !== 81) begin bad++; $display("FAIL inv_count got %0d want 81", obs_q.size()); end
    for (int j = 0; j < 9; j++) begin
      total++;
      if (obs_q[j].addr !== 4'd0) begin
        bad++; $display("FAIL inv_k0[%0d] got %0d want 0", j, obs_q[j].addr);
      end
      total++;
      if (obs_q[9 + j].addr !== 4'(k1_ref[j])) begin
        bad++; $display("FAIL inv_k1[%0d] got %0d want %0d", j, obs_q[9 + j].addr, k1_ref[j]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL inv_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int cyc = 0;
    int dseen = 0;
    int errs = 0;
    bit found = 0;
    @(posedge clk); #1;
    start1 = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    while (!found && cyc < 200) begin
      @(negedge clk);
      if (v1 && k1 == 4'd4 && n1 == 4'd3) found = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("FAIL midrst_reach got %0d want 1", found); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({a1, v1, k1, n1, s1, e1, b1, bz1, d1} !== '0) begin
      bad++;
      $display("FAIL midrst_zero got %h want 0", {a1, v1, k1, n1, s1, e1, b1, bz1, d1});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d1) dseen++;
    end
    total++;
    if (dseen !== 0) begin bad++; $display("FAIL midrst_no_done got %0d want 0", dseen); end
    build_exp(1, 1'b0);
    run_seq(1'b0, 1'b0, 1'b0);
    total++;
    if (obs_q.size() !== 81) begin bad++; $display("FAIL midrst_count got %0d want 81", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL midrst_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_blocks3();
    int errs = 0;
    int sof_blk[$];
    build_exp(3, 1'b0);
    run_seq(1'b1, 1'b0, 1'b0);
    total++;
    if (obs_q.size() !== 243) begin bad++; $display("FAIL blk3_count got %0d want 243", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL blk3_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    foreach (obs_q[i]) if (obs_q[i].sof) sof_blk.push_back(int'(obs_q[i].blk));
    total++;
    if (sof_blk.size() !== 3) begin bad++; $display("FAIL blk3_sof_cnt got %0d want 3", sof_blk.size()); end
    for (int j = 0; j < sof_blk.size() && j < 3; j++) begin
      total++;
      if (sof_blk[j] !== j) begin bad++; $display("FAIL blk3_sof_blk[%0d] got %0d want %0d", j, sof_blk[j], j); end
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL blk3_done_cnt got %0d want 1", done_cnt); end
    total++;
    if (done_cyc !== 243) begin bad++; $display("FAIL blk3_done_cyc got %0d want 243", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ready_toggle();
    test_restart();
`ifdef TWIDDLE9_SEQ_INV_EN
    test_inv();
`endif
    test_reset_mid();
    test_blocks3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
